control_unit_mc: RTL and testbench



---
 rtl/control_unit_mc.sv | 222 ++++++++++++++++++++++
 tb/tb_control_unit_mc.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/control_unit_mc.sv
// rtl/control_unit_mc.sv - multicycle RV32I control unit: sequencing FSM with memory handshake
// Strobes are decoded from the state register and forced low while rst_n is asserted.
module control_unit_mc #(
   parameter bit ENABLE_UPPER    = 1'b1,
   parameter bit TRAP_ON_ILLEGAL = 1'b1,
   parameter int CNT_W           = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [6:0]       op,
   input  logic [2:0]       funct3,
   input  logic [6:0]       funct7,
   input  logic             mem_ready,
   input  logic             branch_taken,
   output logic             mem_req,
   output logic             mem_write,
   output logic             adr_src,
   output logic             ir_write,
   output logic             pc_write,
   output logic             reg_write,
   output logic [1:0]       alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [3:0]       alu_control,
   output logic [1:0]       result_src,
   output logic [2:0]       imm_src,
   output logic [2:0]       load_type,
   output logic [1:0]       store_type,
   output logic             illegal,
   output logic [CNT_W-1:0] retired,
   output logic [3:0]       state_o
);
   // JAL and JALR share their final cycle (JALPC); LUI and AUIPC share UPPER, split on op[5].
   typedef enum logic [3:0] {
      S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
      S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7,
      S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_JAL = 4'd10, S_JALPC = 4'd11,
      S_JALR = 4'd12, S_UPPER = 4'd13, S_ILLEGAL = 4'd14, S_TRAP = 4'd15
   } state_t;

   localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_SLT = 4'b1000,
                          ALU_SLTU = 4'b1001, ALU_PASSB = 4'b1010;

   state_t            state_q, state_d;
   logic              illegal_q, illegal_d;
   logic [CNT_W-1:0]  retired_q, retired_d;
   logic              retire;
   logic              load_ok, store_ok, branch_ok, r_ok, i_ok;
   logic              mem_req_c, mem_write_c, ir_write_c, pc_write_c, reg_write_c;

   function automatic logic [3:0] alu_fn(input logic [2:0] f3, input logic alt);
      case (f3)
         3'd0:    alu_fn = alt ? ALU_SUB : ALU_ADD;
         3'd1:    alu_fn = 4'b0101;
         3'd2:    alu_fn = ALU_SLT;
         3'd3:    alu_fn = ALU_SLTU;
         3'd4:    alu_fn = 4'b0010;
         3'd5:    alu_fn = alt ? 4'b0111 : 4'b0110;
         3'd6:    alu_fn = 4'b0011;
         default: alu_fn = 4'b0100;
      endcase
   endfunction

   always_comb begin
      load_ok   = !(funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7);
      store_ok  = (funct3 <= 3'd2);
      branch_ok = !(funct3 == 3'd2 || funct3 == 3'd3);
      r_ok      = (funct7 == 7'h00) || (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5));
      if (funct3 == 3'd1)      i_ok = (funct7 == 7'h00);
      else if (funct3 == 3'd5) i_ok = (funct7 == 7'h00) || (funct7 == 7'h20);
      else                     i_ok = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
         retired_q <= retired_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (op)
               7'b0000011, 7'b0100011: state_d = S_MEMADR;
               7'b0110011:             state_d = S_EXECR;
               7'b0010011:             state_d = S_EXECI;
               7'b1100011:             state_d = S_BRANCH;
               7'b1101111:             state_d = S_JAL;
               7'b1100111:             state_d = S_JALR;
               7'b0110111, 7'b0010111: state_d = ENABLE_UPPER ? S_UPPER : S_ILLEGAL;
               default:                state_d = S_ILLEGAL;
            endcase
         end
         S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  state_d = !load_ok ? S_ILLEGAL : (mem_ready ? S_MEMWB : S_MEMREAD);
         S_MEMWRITE: state_d = !store_ok ? S_ILLEGAL : (mem_ready ? S_FETCH : S_MEMWRITE);
         S_EXECR:    state_d = r_ok ? S_ALUWB : S_ILLEGAL;
         S_EXECI:    state_d = i_ok ? S_ALUWB : S_ILLEGAL;
         S_BRANCH:   state_d = branch_ok ? S_FETCH : S_ILLEGAL;
         S_JAL, S_JALR: state_d = S_JALPC;
         S_UPPER:    state_d = S_ALUWB;
         S_ILLEGAL:  state_d = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
         S_TRAP:     state_d = S_TRAP;
         default:    state_d = S_FETCH;
      endcase
   end

   always_comb begin
      mem_req_c   = 1'b0;
      mem_write_c = 1'b0;
      ir_write_c  = 1'b0;
      pc_write_c  = 1'b0;
      reg_write_c = 1'b0;
      retire      = 1'b0;
      adr_src     = 1'b0;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      alu_control = ALU_ADD;
      result_src  = 2'b00;
      imm_src     = 3'b000;
      load_type   = 3'b000;
      store_type  = funct3[1:0];
      illegal_d   = illegal_q;
      case (state_q)
         S_FETCH: begin
            mem_req_c  = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            ir_write_c = mem_ready;
            pc_write_c = mem_ready;
         end
         S_DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            imm_src   = (op == 7'b1101111) ? 3'b100 : 3'b010;
         end
         S_MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            imm_src   = op[5] ? 3'b001 : 3'b000;
         end
         S_MEMREAD: begin
            mem_req_c = load_ok;
            adr_src   = 1'b1;
            load_type = funct3[2] ? {1'b0, funct3[0], ~funct3[0]} : {1'b0, funct3[1:0]};
         end
         S_MEMWB: begin
            result_src  = 2'b01;
            reg_write_c = 1'b1;
            retire      = 1'b1;
         end
         S_MEMWRITE: begin
            mem_req_c   = store_ok;
            mem_write_c = store_ok;
            adr_src     = 1'b1;
            retire      = store_ok && mem_ready;
         end
         S_EXECR: begin
            alu_src_a   = 2'b10;
            alu_control = alu_fn(funct3, funct7[5]);
         end
         S_EXECI: begin
            alu_src_a   = 2'b10;
            alu_src_b   = 2'b01;
            alu_control = alu_fn(funct3, funct3 == 3'd5 && funct7[5]);
         end
         S_ALUWB: begin
            reg_write_c = 1'b1;
            retire      = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a   = 2'b10;
            alu_control = funct3[2] ? (funct3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
            pc_write_c  = branch_taken && branch_ok;
            retire      = branch_ok;
         end
         S_JAL: begin
            alu_src_a   = 2'b01;
            alu_src_b   = 2'b10;
            result_src  = 2'b10;
            reg_write_c = 1'b1;
         end
         S_JALR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
         end
         S_JALPC: begin
            // JALR still owes its link write here; JAL wrote rd in its first cycle.
            alu_src_a   = 2'b01;
            alu_src_b   = 2'b10;
            pc_write_c  = 1'b1;
            reg_write_c = !op[3];
            retire      = 1'b1;
         end
         S_UPPER: begin
            alu_src_a   = 2'b01;
            alu_src_b   = 2'b01;
            imm_src     = 3'b011;
            alu_control = op[5] ? ALU_PASSB : ALU_ADD;
         end
         S_ILLEGAL: illegal_d = 1'b1;
         default: ;
      endcase
      retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
   end

   assign mem_req   = mem_req_c   & rst_n;
   assign mem_write = mem_write_c & rst_n;
   assign ir_write  = ir_write_c  & rst_n;
   assign pc_write  = pc_write_c  & rst_n;
   assign reg_write = reg_write_c & rst_n;
   assign illegal   = illegal_q;
   assign retired   = retired_q;
   assign state_o   = state_q;
endmodule

// File: tb/tb_control_unit_mc.sv
// tb/tb_control_unit_mc.sv - scoreboard bench for control_unit_mc
module tb_control_unit_mc;
   localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3,
                          MEMWB = 4'd4, MEMWRITE = 4'd5, EXECR = 4'd6, EXECI = 4'd7,
                          ALUWB = 4'd8, BRANCH = 4'd9, JAL = 4'd10, JALPC = 4'd11,
                          UPPER = 4'd13, ILLEGAL = 4'd14, TRAP = 4'd15;

   logic        clk = 1'b0;
   logic        rst_n, mem_ready, branch_taken;
   logic [6:0]  op, funct7;
   logic [2:0]  funct3;
   logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal;
   logic [1:0]  alu_src_a, alu_src_b, result_src, store_type;
   logic [3:0]  alu_control, state_o;
   logic [2:0]  imm_src, load_type;
   logic [31:0] retired;

   control_unit_mc dut (
      .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7),
      .mem_ready(mem_ready), .branch_taken(branch_taken), .mem_req(mem_req),
      .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
      .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_control(alu_control), .result_src(result_src), .imm_src(imm_src),
      .load_type(load_type), .store_type(store_type), .illegal(illegal),
      .retired(retired), .state_o(state_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [3:0]  st;
      logic [4:0]  strb;
      logic [31:0] ret;
      logic        ill;
      int          alu;
      int          rs;
      int          adr;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   // strobe vector order: {mem_req, mem_write, ir_write, pc_write, reg_write}; -1 skips a field
   task automatic ex(input string n, input logic [3:0] st, input logic [4:0] sb,
                     input logic [31:0] rt, input logic il,
                     input int alu = -1, input int rs = -1, input int adr = -1);
      exp_t e;
      e.name = n; e.st = st; e.strb = sb; e.ret = rt; e.ill = il;
      e.alu = alu; e.rs = rs; e.adr = adr;
      q.push_back(e);
   endtask

   task automatic tk();
      @(posedge clk);
      #1;
   endtask

   task automatic cmp(input string n, input string f, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s.%s actual=%0h required=%0h", n, f, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         cmp(e.name, "state", {28'd0, state_o}, {28'd0, e.st});
         cmp(e.name, "strobes", {27'd0, mem_req, mem_write, ir_write, pc_write, reg_write},
             {27'd0, e.strb});
         cmp(e.name, "retired", retired, e.ret);
         cmp(e.name, "illegal", {31'd0, illegal}, {31'd0, e.ill});
         if (e.alu >= 0) cmp(e.name, "alu_control", {28'd0, alu_control}, e.alu);
         if (e.rs >= 0)  cmp(e.name, "result_src", {30'd0, result_src}, e.rs);
         if (e.adr >= 0) cmp(e.name, "adr_src", {31'd0, adr_src}, e.adr);
      end
   end

   task automatic set_ir(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
      op = o; funct3 = f3; funct7 = f7;
   endtask

   task automatic fetch_decode(input string n, input logic [31:0] rt);
      mem_ready = 1'b1;
      ex({n, "_fetch"}, FETCH, 5'b10110, rt, 1'b0, 0, 2, 0);
      tk();
      ex({n, "_decode"}, DECODE, 5'b00000, rt, 1'b0, 0);
      tk();
   endtask

   initial begin
      rst_n = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0;
      set_ir(7'b0110011, 3'd0, 7'h00);
      tk();
      ex("reset1", FETCH, 5'b00000, 0, 1'b0);
      tk();
      ex("reset2", FETCH, 5'b00000, 0, 1'b0);
      tk();
      rst_n = 1'b1;

      fetch_decode("add", 0);
      ex("add_execr", EXECR, 5'b00000, 0, 1'b0, 0);
      tk();
      ex("add_aluwb", ALUWB, 5'b00001, 0, 1'b0, -1, 0);
      tk();

      set_ir(7'b0000011, 3'd2, 7'h00);
      fetch_decode("lw", 1);
      mem_ready = 1'b0;
      ex("lw_memadr", MEMADR, 5'b00000, 1, 1'b0, 0);
      tk();
      for (int i = 0; i < 3; i++) begin
         ex("lw_wait", MEMREAD, 5'b10000, 1, 1'b0, -1, -1, 1);
         tk();
      end
      mem_ready = 1'b1;
      ex("lw_ready", MEMREAD, 5'b10000, 1, 1'b0, -1, -1, 1);
      tk();
      ex("lw_memwb", MEMWB, 5'b00001, 1, 1'b0, -1, 1);
      tk();

      set_ir(7'b0010011, 3'd5, 7'h20);
      fetch_decode("srai", 2);
      ex("srai_execi", EXECI, 5'b00000, 2, 1'b0, 7);
      tk();
      ex("srai_aluwb", ALUWB, 5'b00001, 2, 1'b0, -1, 0);
      tk();

      set_ir(7'b1100011, 3'd0, 7'h00);
      branch_taken = 1'b1;
      fetch_decode("beq", 3);
      ex("beq_branch", BRANCH, 5'b00010, 3, 1'b0, 1);
      tk();
      set_ir(7'b1100011, 3'd1, 7'h00);
      branch_taken = 1'b0;
      fetch_decode("bne", 4);
      ex("bne_branch", BRANCH, 5'b00000, 4, 1'b0, 1);
      tk();

      set_ir(7'b1101111, 3'd0, 7'h00);
      fetch_decode("jal", 5);
      ex("jal_link", JAL, 5'b00001, 5, 1'b0, 0, 2);
      tk();
      ex("jal_pc", JALPC, 5'b00010, 5, 1'b0);
      tk();

      set_ir(7'b0110111, 3'd0, 7'h00);
      fetch_decode("lui", 6);
      ex("lui_upper", UPPER, 5'b00000, 6, 1'b0, 10);
      tk();
      ex("lui_aluwb", ALUWB, 5'b00001, 6, 1'b0, -1, 0);
      tk();

      set_ir(7'b0100011, 3'd2, 7'h00);
      fetch_decode("sw", 7);
      mem_ready = 1'b0;
      ex("sw_memadr", MEMADR, 5'b00000, 7, 1'b0, 0);
      tk();
      ex("sw_wait", MEMWRITE, 5'b11000, 7, 1'b0, -1, -1, 1);
      tk();
      rst_n = 1'b0;
      ex("sw_reset", MEMWRITE, 5'b00000, 7, 1'b0);
      tk();
      ex("sw_after_reset", FETCH, 5'b00000, 0, 1'b0);
      tk();
      rst_n = 1'b1;

      set_ir(7'b0010011, 3'd5, 7'h10);
      fetch_decode("bad_srai", 0);
      ex("bad_execi", EXECI, 5'b00000, 0, 1'b0);
      tk();
      ex("bad_illegal", ILLEGAL, 5'b00000, 0, 1'b0);
      tk();
      for (int i = 0; i < 20; i++) begin
         ex("trap_hold", TRAP, 5'b00000, 0, 1'b1);
         tk();
      end

      @(negedge clk);
      #1;
      cmp("scoreboard", "pending", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
